fb_arbiter: RTL and testbench
=============================

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13: framebuffer address width.
REQ-002 Parameter DATA_W, default 8: pixel/word width.
REQ-003 Parameter FIFO_DEPTH, default 4, power of two >= 2: write-buffer entries.
REQ-004 clk  in  1  system clock; all state on posedge clk.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 clk_en  in  1  pixel-rate enable, same strobe that advances the scan counters.
REQ-007 hblank, vblank  in  1 each  blanking flags from the scan counters.
REQ-008 vid_addr  in  ADDR_W  framebuffer address of the current pixel.
REQ-009 wr_valid, wr_addr, wr_data  in  1/ADDR_W/DATA_W  writer push request (matrix-result side).
REQ-010 wr_ready  out  1  writer may push this cycle.
REQ-011 mem_en, mem_we  out  1 each  single-port BRAM enable/write-enable.
REQ-012 mem_addr, mem_wdata  out  ADDR_W/DATA_W  BRAM address/write data.
REQ-013 mem_rdata  in  DATA_W  BRAM read data, valid 1 cycle after a read.
REQ-014 vid_pixel  out  DATA_W  registered pixel to the VGA output stage.
REQ-015 vid_valid  out  1  one-cycle strobe: vid_pixel updated.
REQ-016 fifo_level  out  $clog2(FIFO_DEPTH)+1  current write-buffer occupancy.
REQ-017 wr_commits  out  16  count of writes committed to BRAM, wraps 0xFFFF->0.

Function
REQ-018 Video slot = clk_en & ~hblank & ~vblank; blank slot = clk_en & (hblank | vblank).
REQ-019 Owner per cycle, combinational, priority order: VID (video slot), WR (FIFO non-empty), NONE.
REQ-020 VID: mem_en=1, mem_we=0, mem_addr=vid_addr; video is never stalled or delayed.
REQ-021 WR: mem_en=1, mem_we=1, mem_addr/mem_wdata = FIFO head; head popped at that edge; wr_commits +1.
REQ-022 NONE: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-023 Registered owner/slot state GNT in {NONE, VID, BLANK, WR}, updated every cycle: BLANK when a blank slot occurs with no VID, else owner of that cycle.
REQ-024 Cycle after GNT==VID: vid_pixel <= mem_rdata, vid_valid=1 (total latency 2 edges from slot).
REQ-025 Cycle after GNT==BLANK: vid_pixel <= 0, vid_valid=1; blank slot does not block WR that cycle.
REQ-026 Otherwise vid_valid=0, vid_pixel holds.
REQ-027 FIFO: push when wr_valid & wr_ready; wr_ready = (fifo_level < FIFO_DEPTH); order preserved.
REQ-028 Full FIFO: wr_ready=0 even if a pop occurs same cycle; no push is ever lost or overwritten.
REQ-029 Empty FIFO with push: entry not committable until the next cycle (no bypass).
REQ-030 Simultaneous push and pop (not full): fifo_level unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-031 wr_valid while wr_ready=0: ignored; writer holds data until accepted.
REQ-032 Read-after-write: a video read in the cycle after a WR to the same address returns the new data.

Reset
REQ-033 reset asserted: FIFO emptied, pointers 0, fifo_level=0, wr_commits=0, GNT=NONE, vid_pixel=0, vid_valid=0.
REQ-034 During reset: wr_ready=0, mem_en=0, mem_we=0; buffered writes are discarded, not committed.
REQ-035 Reset mid-pixel-pipeline: pending read return dropped; first vid_valid only after a new slot post-reset.

Verification
REQ-036 Reset, clk_en every 4th cycle, visible line, vid_addr=0x10, BRAM[0x10]=0xA5 -> vid_pixel=0xA5, vid_valid 2 edges after slot.
REQ-037 Hblank slot during FIFO holding 1 entry -> WR same cycle, vid_pixel=0x00 with vid_valid next cycle, wr_commits=1.
REQ-038 Push 5 writes back-to-back during continuous video slots (clk_en=1) -> 4 accepted, wr_ready=0 on 5th, fifo_level=4, no BRAM writes.
REQ-039 Then drop clk_en -> FIFO drains one per cycle in push order, fifo_level 4->0, wr_commits=4.
REQ-040 Write 0x3C to 0x20, next cycle video slot at 0x20 -> vid_pixel=0x3C.
REQ-041 Reset asserted with fifo_level=3 mid-frame -> outputs per REQ-033/034 immediately, no mem_we pulse, wr_commits=0.

Source files
------------

// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one BRAM port between never-stalled video reads (vid_addr -> vid_pixel/vid_valid) and a buffered writer (wr_* -> FIFO -> mem_*), reporting fifo_level and wr_commits
module fb_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clk_en,
  input  logic                          hblank,
  input  logic                          vblank,
  input  logic [ADDR_W-1:0]             vid_addr,
  input  logic                          wr_valid,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_ready,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [DATA_W-1:0]             vid_pixel,
  output logic                          vid_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   wr_commits
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {NONE, VID, BLANK, WR} gnt_t;
  gnt_t gnt;
  logic [ADDR_W-1:0] fa [FIFO_DEPTH];
  logic [DATA_W-1:0] fd [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic vid_slot, blank_slot, own_vid, own_wr, push;
  assign vid_slot   = clk_en & ~hblank & ~vblank;
  assign blank_slot = clk_en & (hblank | vblank);
  assign own_vid    = vid_slot & ~reset;
  assign own_wr     = ~vid_slot & (fifo_level != '0) & ~reset;
  assign wr_ready   = ~reset & (fifo_level < (PW+1)'(FIFO_DEPTH));
  assign push       = wr_valid & wr_ready;
  assign mem_en     = own_vid | own_wr;
  assign mem_we     = own_wr;
  assign mem_addr   = own_vid ? vid_addr : own_wr ? fa[rp] : '0;
  assign mem_wdata  = own_wr ? fd[rp] : '0;
  always_ff @(posedge clk)
    if (push) begin
      fa[wp] <= wr_addr;
      fd[wp] <= wr_data;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
      wr_commits <= '0;
      gnt        <= NONE;
      vid_pixel  <= '0;
      vid_valid  <= 1'b0;
    end else begin
      wp         <= wp + PW'(push);
      rp         <= rp + PW'(own_wr);
      fifo_level <= fifo_level + (PW+1)'(push) - (PW+1)'(own_wr);
      wr_commits <= wr_commits + 16'(own_wr);
      gnt        <= own_vid ? VID : blank_slot ? BLANK : own_wr ? WR : NONE;
      vid_valid  <= (gnt == VID) || (gnt == BLANK);
      vid_pixel  <= (gnt == VID) ? mem_rdata : (gnt == BLANK) ? '0 : vid_pixel;
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed stimulus with pixel/write scoreboards checked by a negedge monitor
module tb_fb_arbiter;
  logic clk = 1'b0, reset = 1'b1, clk_en = 1'b0, hblank = 1'b0, vblank = 1'b0;
  logic [12:0] vid_addr = '0, wr_addr = '0, mem_addr;
  logic wr_valid = 1'b0, wr_ready, mem_en, mem_we, vid_valid;
  logic [7:0] wr_data = '0, mem_wdata, mem_rdata = '0, vid_pixel;
  logic [2:0] fifo_level;
  logic [15:0] wr_commits;
  logic pre_en = 1'b0;
  logic [12:0] pre_addr = '0;
  logic [7:0] pre_data = '0;
  logic [7:0] bram [0:8191];
  int cyc = 0, n_checks = 0, n_fail = 0;
  typedef struct {logic [7:0] px; int due;} pix_t;
  typedef struct {logic [12:0] a; logic [7:0] d;} wr_t;
  pix_t pq [$];
  wr_t wq [$];
  pix_t p;
  wr_t w;

  fb_arbiter dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .hblank(hblank), .vblank(vblank),
    .vid_addr(vid_addr), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .vid_pixel(vid_pixel),
    .vid_valid(vid_valid), .fifo_level(fifo_level), .wr_commits(wr_commits)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (pre_en) bram[pre_addr] <= pre_data;
    else if (mem_en && mem_we) bram[mem_addr] <= mem_wdata;
    else if (mem_en) mem_rdata <= bram[mem_addr];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk)
    if (!reset) begin
      if (vid_valid) begin
        if (pq.size() == 0) chk("vid_valid_unexpected", int'(vid_valid), 0);
        else begin
          p = pq.pop_front();
          chk("vid_pixel", int'(vid_pixel), int'(p.px));
          chk("vid_latency", cyc, p.due);
        end
      end else if (pq.size() > 0 && pq[0].due <= cyc) begin
        chk("vid_valid_missing", int'(vid_valid), 1);
        void'(pq.pop_front());
      end
      if (mem_en && mem_we) begin
        if (wq.size() == 0) chk("mem_we_unexpected", int'(mem_we), 0);
        else begin
          w = wq.pop_front();
          chk("mem_addr", int'(mem_addr), int'(w.a));
          chk("mem_wdata", int'(mem_wdata), int'(w.d));
        end
      end
    end

  task automatic step(input int ce, input int hb, input int vb, input int va, input int px,
                      input int wv, input int wa, input int wd, input int rdy, input int we);
    clk_en = 1'(ce); hblank = 1'(hb); vblank = 1'(vb); vid_addr = 13'(va);
    wr_valid = 1'(wv); wr_addr = 13'(wa); wr_data = 8'(wd);
    #2;
    chk("mem_we", int'(mem_we), we);
    if (wv != 0) chk("wr_ready", int'(wr_ready), rdy);
    if (ce != 0) pq.push_back('{8'(px), cyc + 2});
    if (wv != 0 && rdy != 0) wq.push_back('{13'(wa), 8'(wd)});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_state(input string tag);
    chk({tag, "_wr_ready"}, int'(wr_ready), 0);
    chk({tag, "_mem_en"}, int'(mem_en), 0);
    chk({tag, "_mem_we"}, int'(mem_we), 0);
    chk({tag, "_fifo_level"}, int'(fifo_level), 0);
    chk({tag, "_wr_commits"}, int'(wr_commits), 0);
    chk({tag, "_vid_valid"}, int'(vid_valid), 0);
    chk({tag, "_vid_pixel"}, int'(vid_pixel), 0);
  endtask

  initial begin
    clk_en = 1'b1; wr_valid = 1'b1; wr_addr = 13'h1FF; wr_data = 8'hEE;
    pre_en = 1'b1; pre_addr = 13'h010; pre_data = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    reset_state("rst");
    pre_en = 1'b0; clk_en = 1'b0; wr_valid = 1'b0;
    reset = 1'b0;
    chk("post_rst_level", int'(fifo_level), 0);
    // visible line, one pixel every 4th cycle
    for (int i = 0; i < 8; i++) step((i % 4 == 0) ? 1 : 0, 0, 0, 'h10, 'hA5, 0, 0, 0, 0, 0);
    // one buffered write, then committed under an hblank slot
    step(1, 0, 0, 'h10, 'hA5, 1, 'h100, 'h11, 1, 0);
    step(1, 1, 0, 'h10, 'h00, 0, 0, 0, 0, 1);
    idle(2);
    chk("commits_after_blank", int'(wr_commits), 1);
    // back-to-back pushes while video owns every cycle
    for (int i = 0; i < 5; i++) step(1, 0, 0, 'h10, 'hA5, 1, 'h200 + i, 'h50 + i, (i < 4) ? 1 : 0, 0);
    chk("full_level", int'(fifo_level), 4);
    chk("full_commits", int'(wr_commits), 1);
    // drain with clk_en low; writer still holding the rejected 5th write on the first cycle
    for (int i = 0; i < 4; i++) begin
      chk("drain_level", int'(fifo_level), 4 - i);
      step(0, 0, 0, 0, 0, (i == 0) ? 1 : 0, 'h204, 'h54, 0, 1);
    end
    chk("drained_level", int'(fifo_level), 0);
    chk("drained_commits", int'(wr_commits), 5);
    // read-after-write, no bypass on an empty FIFO, vblank slot
    step(0, 0, 0, 0, 0, 1, 'h20, 'h3C, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 'h20, 'h3C, 0, 0, 0, 0, 0);
    step(1, 0, 1, 'h20, 'h00, 0, 0, 0, 0, 0);
    idle(3);
    chk("raw_commits", int'(wr_commits), 6);
    // reset mid-frame with 3 buffered writes and reads in flight
    for (int i = 0; i < 3; i++) step(1, 0, 0, 'h10, 'hA5, 1, 'h300 + i, 'h70 + i, 1, 0);
    chk("pre_reset_level", int'(fifo_level), 3);
    clk_en = 1'b1; hblank = 1'b0; vblank = 1'b0; wr_valid = 1'b1;
    reset = 1'b1;
    #1;
    reset_state("midrst");
    pq.delete();
    wq.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_hold_mem_en", int'(mem_en), 0);
    reset = 1'b0; clk_en = 1'b0; wr_valid = 1'b0;
    idle(3);
    step(1, 0, 0, 'h20, 'h3C, 0, 0, 0, 0, 0);
    idle(4);
    chk("final_commits", int'(wr_commits), 0);
    chk("final_level", int'(fifo_level), 0);
    chk("pix_queue_empty", pq.size(), 0);
    chk("wr_queue_empty", wq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
